text_console: RTL and testbench

Character-stream writer for the VGA text framebuffer. It accepts one 8-bit character per valid/ready handshake, keeps a cursor, and turns printable codes and a small set of control codes into single-cell writes on the framebuffer RAM write port (`framebuffer_data`, `framebuffer_addr`, `framebuffer_write_enable`). Line wrap, line clear and full-screen clear are multi-cycle fill sequences. It sits directly upstream of the framebuffer display stage, between the CPU I/O interface and the framebuffer write port.

---
 rtl/text_console.sv | 154 +++++++++++++++
 tb/tb_text_console.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-stream writer: cursor tracking plus single-cell and fill writes into the text framebuffer.
// Optional TEXT_CONSOLE_RESET_CLEAR_EN: clear the whole screen automatically when reset is released.
module text_console #(
    parameter int          COLS      = 98,
    parameter int          ROWS      = 35,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  framebuffer_data,
    output logic [11:0] framebuffer_addr,
    output logic        framebuffer_write_enable,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
    localparam logic [12:0] STRIDE   = 13'(COLS);
    localparam logic [11:0] STRIDE12 = 12'(COLS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, LINE, SCREEN} state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [11:0] base_q, base_d;
    logic [12:0] fill_q, fill_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        do_lf;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        fill_d  = fill_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        do_lf   = 1'b0;
        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    case (char_data)
                        8'h0D: col_d = '0;
                        8'h0A: do_lf = 1'b1;
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d  = col_q - 7'd1;
                                we_d   = 1'b1;
                                addr_d = base_q + 12'(col_q) - 12'd1;
                                data_d = FILL_CHAR;
                            end
                        end
                        8'h0C: begin
                            // Cell 0 is written on the acceptance edge; the SCREEN state continues from cell 1.
                            col_d   = '0;
                            row_d   = '0;
                            base_d  = '0;
                            we_d    = 1'b1;
                            addr_d  = '0;
                            data_d  = FILL_CHAR;
                            fill_d  = 13'd1;
                            state_d = SCREEN;
                        end
                        default: begin
                            we_d   = 1'b1;
                            addr_d = base_q + 12'(col_q);
                            data_d = char_data;
                            if (col_q == LAST_COL) do_lf = 1'b1;
                            else                   col_d = col_q + 7'd1;
                        end
                    endcase
                    if (do_lf) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d  = '0;
                            base_d = '0;
                        end else begin
                            row_d  = row_q + 6'd1;
                            base_d = base_q + STRIDE12;
                        end
                        fill_d  = {1'b0, base_d};
                        state_d = LINE;
                    end
                end
            end
            LINE: begin
                if (fill_q == {1'b0, base_q} + STRIDE) begin
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = fill_q[11:0];
                    data_d = FILL_CHAR;
                    fill_d = fill_q + 13'd1;
                end
            end
            SCREEN: begin
                if (fill_q == CELLS) begin
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = fill_q[11:0];
                    data_d = FILL_CHAR;
                    fill_d = fill_q + 13'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef TEXT_CONSOLE_RESET_CLEAR_EN
            state_q <= SCREEN;
`else
            state_q <= IDLE;
`endif
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
            fill_q <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            fill_q  <= fill_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign char_ready               = (state_q == IDLE);
    assign busy                     = ~char_ready;
    assign framebuffer_write_enable = we_q;
    assign framebuffer_addr         = addr_q;
    assign framebuffer_data         = data_q;
    assign cursor_col               = col_q;
    assign cursor_row               = row_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console at the default 98x35 geometry: vector table plus fill/reset sequences.
module tb_text_console;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  framebuffer_data;
    logic [11:0] framebuffer_addr;
    logic        framebuffer_write_enable;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    text_console dut (
        .clk                      (clk),
        .rst                      (rst),
        .char_data                (char_data),
        .char_valid               (char_valid),
        .char_ready               (char_ready),
        .framebuffer_data         (framebuffer_data),
        .framebuffer_addr         (framebuffer_addr),
        .framebuffer_write_enable (framebuffer_write_enable),
        .cursor_col               (cursor_col),
        .cursor_row               (cursor_row),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ch;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
        logic [6:0]  col;
        logic [5:0]  row;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        char_data  = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    // Walks a fill from the current sample point until char_ready returns; the first 'pre' cycles are not fill cells.
    task automatic observe(input int first, input int pre, output int lows, output int fills, output int bad);
        lows  = 0;
        fills = 0;
        bad   = 0;
        for (int k = 0; k < 5000 && !char_ready; k++) begin
            lows++;
            if (k >= pre) begin
                if (!framebuffer_write_enable || framebuffer_addr !== 12'(first + fills) ||
                    framebuffer_data !== 8'h20)
                    bad++;
                fills++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lows, fills, bad, acc_bad, acc_low;

        vecs[0]  = '{8'h41, 1'b1, 12'd0, 8'h41, 7'd1, 6'd0};
        vecs[1]  = '{8'h42, 1'b1, 12'd1, 8'h42, 7'd2, 6'd0};
        vecs[2]  = '{8'h0D, 1'b0, 12'd1, 8'h42, 7'd0, 6'd0};
        vecs[3]  = '{8'h01, 1'b1, 12'd0, 8'h01, 7'd1, 6'd0};
        vecs[4]  = '{8'h78, 1'b1, 12'd1, 8'h78, 7'd2, 6'd0};
        vecs[5]  = '{8'h79, 1'b1, 12'd2, 8'h79, 7'd3, 6'd0};
        vecs[6]  = '{8'h7A, 1'b1, 12'd3, 8'h7A, 7'd4, 6'd0};
        vecs[7]  = '{8'h71, 1'b1, 12'd4, 8'h71, 7'd5, 6'd0};
        vecs[8]  = '{8'h08, 1'b1, 12'd4, 8'h20, 7'd4, 6'd0};
        vecs[9]  = '{8'h08, 1'b1, 12'd3, 8'h20, 7'd3, 6'd0};
        vecs[10] = '{8'h0D, 1'b0, 12'd3, 8'h20, 7'd0, 6'd0};
        vecs[11] = '{8'h08, 1'b0, 12'd3, 8'h20, 7'd0, 6'd0};
        vecs[12] = '{8'h1B, 1'b1, 12'd0, 8'h1B, 7'd1, 6'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(framebuffer_write_enable), 32'd0);
        chk("rst_addr", 32'(framebuffer_addr), 32'd0);
        chk("rst_data", 32'(framebuffer_data), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
`ifdef TEXT_CONSOLE_RESET_CLEAR_EN
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
`else
        chk("rst_ready", 32'(char_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
`ifdef TEXT_CONSOLE_RESET_CLEAR_EN
        @(posedge clk);
        #1;
        observe(0, 0, lows, fills, bad);
        chk("boot_clear_lows", 32'(lows), 32'd3430);
        chk("boot_clear_cells", 32'(fills), 32'd3430);
        chk("boot_clear_bad", 32'(bad), 32'd0);
`endif

        // Single-character vectors
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].ch);
            $display("vec %0d: ch=%02h we=%0b addr=%0d data=%02h col=%0d row=%0d", i, vecs[i].ch,
                     framebuffer_write_enable, framebuffer_addr, framebuffer_data, cursor_col, cursor_row);
            chk($sformatf("v%0d_we", i), 32'(framebuffer_write_enable), 32'(vecs[i].we));
            chk($sformatf("v%0d_addr", i), 32'(framebuffer_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_data", i), 32'(framebuffer_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_col", i), 32'(cursor_col), 32'(vecs[i].col));
            chk($sformatf("v%0d_row", i), 32'(cursor_row), 32'(vecs[i].row));
            chk($sformatf("v%0d_ready", i), 32'(char_ready), 32'd1);
        end

        // Back-to-back A, B
        send(8'h0D);
        @(negedge clk);
        char_data  = 8'h41;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("b2b A: we=%0b addr=%0d data=%02h", framebuffer_write_enable, framebuffer_addr, framebuffer_data);
        chk("b2b_a_we", 32'(framebuffer_write_enable), 32'd1);
        chk("b2b_a_addr", 32'(framebuffer_addr), 32'd0);
        chk("b2b_a_ready", 32'(char_ready), 32'd1);
        @(negedge clk);
        char_data = 8'h42;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        $display("b2b B: we=%0b addr=%0d data=%02h", framebuffer_write_enable, framebuffer_addr, framebuffer_data);
        chk("b2b_b_we", 32'(framebuffer_write_enable), 32'd1);
        chk("b2b_b_addr", 32'(framebuffer_addr), 32'd1);
        chk("b2b_b_data", 32'(framebuffer_data), 32'h42);
        chk("b2b_b_col", 32'(cursor_col), 32'd2);
        chk("b2b_b_ready", 32'(char_ready), 32'd1);

        // Full row of 'A' then wrap-triggered line clear of row 1
        send(8'h0D);
        acc_bad = 0;
        for (int i = 0; i < 98; i++) begin
            @(negedge clk);
            char_data  = 8'h41;
            char_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i < 97 && (!char_ready || !framebuffer_write_enable || framebuffer_addr !== 12'(i)))
                acc_bad++;
        end
        char_valid = 1'b0;
        $display("row fill last: we=%0b addr=%0d col=%0d row=%0d ready=%0b", framebuffer_write_enable,
                 framebuffer_addr, cursor_col, cursor_row, char_ready);
        chk("row_stream_bad", 32'(acc_bad), 32'd0);
        chk("wrap_we", 32'(framebuffer_write_enable), 32'd1);
        chk("wrap_addr", 32'(framebuffer_addr), 32'd97);
        chk("wrap_data", 32'(framebuffer_data), 32'h41);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);
        chk("wrap_ready", 32'(char_ready), 32'd0);
        observe(98, 1, lows, fills, bad);
        $display("line clear row1: lows=%0d cells=%0d bad=%0d", lows, fills, bad);
        chk("line1_lows", 32'(lows), 32'd99);
        chk("line1_cells", 32'(fills), 32'd98);
        chk("line1_bad", 32'(bad), 32'd0);
        chk("line1_end_we", 32'(framebuffer_write_enable), 32'd0);

        // LF down to row 34, then LF wraps to row 0 and clears it
        acc_bad = 0;
        acc_low = 0;
        for (int r = 2; r <= 34; r++) begin
            send(8'h0A);
            observe(r * 98, 1, lows, fills, bad);
            if (bad != 0 || fills != 98 || lows != 99) acc_bad++;
        end
        chk("lf_walk_bad", 32'(acc_bad), 32'd0);
        chk("lf_walk_row", 32'(cursor_row), 32'd34);
        send(8'h0A);
        $display("lf wrap: we=%0b col=%0d row=%0d ready=%0b", framebuffer_write_enable, cursor_col, cursor_row,
                 char_ready);
        chk("lfwrap_row", 32'(cursor_row), 32'd0);
        chk("lfwrap_we", 32'(framebuffer_write_enable), 32'd0);
        observe(0, 1, lows, fills, bad);
        chk("line0_lows", 32'(lows), 32'd99);
        chk("line0_cells", 32'(fills), 32'd98);
        chk("line0_bad", 32'(bad), 32'd0);

        // Backspace at col 5 on row 1
        send(8'h0A);
        observe(98, 1, lows, fills, bad);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h08);
        $display("bs row1: we=%0b addr=%0d data=%02h col=%0d", framebuffer_write_enable, framebuffer_addr,
                 framebuffer_data, cursor_col);
        chk("bs_we", 32'(framebuffer_write_enable), 32'd1);
        chk("bs_addr", 32'(framebuffer_addr), 32'd102);
        chk("bs_data", 32'(framebuffer_data), 32'h20);
        chk("bs_col", 32'(cursor_col), 32'd4);

        // Form feed: full screen clear
        send(8'h0C);
        chk("ff_col", 32'(cursor_col), 32'd0);
        chk("ff_row", 32'(cursor_row), 32'd0);
        chk("ff_ready", 32'(char_ready), 32'd0);
        observe(0, 0, lows, fills, bad);
        $display("ff clear: lows=%0d cells=%0d bad=%0d", lows, fills, bad);
        chk("ff_lows", 32'(lows), 32'd3430);
        chk("ff_cells", 32'(fills), 32'd3430);
        chk("ff_bad", 32'(bad), 32'd0);
        chk("ff_end_we", 32'(framebuffer_write_enable), 32'd0);

        // Reset in the middle of a screen clear
        send(8'h51);
        send(8'h0C);
        repeat (999) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pre_we", 32'(framebuffer_write_enable), 32'd1);
        chk("abort_pre_addr", 32'(framebuffer_addr), 32'd999);
        #1;
        rst = 1'b0;
        #1;
        $display("abort: we=%0b col=%0d row=%0d ready=%0b", framebuffer_write_enable, cursor_col, cursor_row,
                 char_ready);
        chk("abort_we", 32'(framebuffer_write_enable), 32'd0);
        chk("abort_col", 32'(cursor_col), 32'd0);
        chk("abort_row", 32'(cursor_row), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
`ifdef TEXT_CONSOLE_RESET_CLEAR_EN
        observe(0, 0, lows, fills, bad);
        chk("restart_lows", 32'(lows), 32'd3430);
        chk("restart_cells", 32'(fills), 32'd3430);
        chk("restart_bad", 32'(bad), 32'd0);
`else
        acc_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (framebuffer_write_enable || !char_ready) acc_bad++;
            @(posedge clk);
            #1;
        end
        chk("post_abort_idle", 32'(acc_bad), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
